// File: rtl/hsm_bus_transceiver.sv
`default_nettype none
// ============================================================================
// hsm_bus_transceiver
// Registered bidirectional HSM bus transceiver with synchronised direction
// control, high-Z turnaround, write handshake and strobed read capture.
// Revision: 1.0
// ============================================================================
module hsm_bus_transceiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_select,
  input  logic                  pin_strobe,
  inout  wire  [DATA_WIDTH-1:0] data_pins,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  hsm_strobe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  drive_en
);

  localparam int               CNT_W      = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] C_PH_IDLE   = 2'd0;
  localparam logic [1:0] C_PH_HOLD   = 2'd1;
  localparam logic [1:0] C_PH_STROBE = 2'd2;

  typedef enum logic [2:0] {
    ST_TURN  = 3'b001,
    ST_READ  = 3'b010,
    ST_WRITE = 3'b100
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_st_sync;
  logic                   r_st_d;
  logic [DATA_WIDTH-1:0]  r_pin_q;
  logic [DATA_WIDTH-1:0]  r_out_q;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_phase;

  logic w_cs_s;
  logic w_st_rise;
  logic w_accept;

  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_st_rise = r_st_sync[SYNC_STAGES-1] & ~r_st_d;
  assign w_accept  = tx_valid & tx_ready;

  // The WRITE one-hot bit doubles as the pad output enable.
  assign drive_en  = r_state[2];
  assign data_pins = drive_en ? r_out_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_sync <= '0;
      r_st_sync <= '0;
      r_st_d    <= 1'b0;
      r_pin_q   <= '0;
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], chip_select};
      r_st_sync <= {r_st_sync[SYNC_STAGES-2:0], pin_strobe};
      r_st_d    <= r_st_sync[SYNC_STAGES-1];
      r_pin_q   <= data_pins;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_TURN;
      r_cnt      <= C_CNT_LOAD;
      r_phase    <= C_PH_IDLE;
      r_out_q    <= '0;
      tx_ready   <= 1'b0;
      hsm_strobe <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_valid   <= 1'b0;
      hsm_strobe <= 1'b0;
      case (r_state)
        ST_TURN: begin
          // Direction is chosen from chip_select as seen at the end of the gap.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end else if (w_cs_s) begin
            r_state <= ST_READ;
          end else begin
            r_state  <= ST_WRITE;
            r_phase  <= C_PH_IDLE;
            tx_ready <= 1'b1;
          end
        end
        ST_READ: begin
          if (w_st_rise) begin
            rx_data  <= r_pin_q;
            rx_valid <= 1'b1;
          end
          if (!w_cs_s) begin
            r_state <= ST_TURN;
            r_cnt   <= C_CNT_LOAD;
          end
        end
        ST_WRITE: begin
          if (w_cs_s) begin
            r_state  <= ST_TURN;
            r_cnt    <= C_CNT_LOAD;
            r_phase  <= C_PH_IDLE;
            tx_ready <= 1'b0;
          end else begin
            case (r_phase)
              C_PH_IDLE: begin
                if (w_accept) begin
                  r_out_q  <= tx_data;
                  r_phase  <= C_PH_HOLD;
                  tx_ready <= 1'b0;
                end
              end
              C_PH_HOLD: begin
                r_phase    <= C_PH_STROBE;
                hsm_strobe <= 1'b1;
              end
              default: begin
                r_phase  <= C_PH_IDLE;
                tx_ready <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          r_state  <= ST_TURN;
          r_cnt    <= C_CNT_LOAD;
          r_phase  <= C_PH_IDLE;
          tx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hsm_bus_transceiver.sv
`default_nettype none
// ============================================================================
// tb_hsm_bus_transceiver
// Directed scenarios plus randomized traffic against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_hsm_bus_transceiver;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int T  = 2;

  logic          clk         = 1'b0;
  logic          rst         = 1'b1;
  logic          chip_select = 1'b0;
  logic          pin_strobe  = 1'b0;
  logic          tx_valid    = 1'b0;
  logic [DW-1:0] tx_data     = '0;
  logic [DW-1:0] tb_pin_val  = '0;
  wire  [DW-1:0] data_pins;
  logic          tx_ready;
  logic          hsm_strobe;
  logic          rx_valid;
  logic          drive_en;
  logic [DW-1:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // HSM side drives the bus whenever the FPGA is not driving it.
  assign data_pins = drive_en ? {DW{1'bz}} : tb_pin_val;

  hsm_bus_transceiver #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(S),
    .TURNAROUND (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .chip_select(chip_select),
    .pin_strobe (pin_strobe),
    .data_pins  (data_pins),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .hsm_strobe (hsm_strobe),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .drive_en   (drive_en)
  );

  // ---------------- behavioural reference model ----------------
  typedef enum int {M_TURN, M_READ, M_WRITE} mode_t;
  mode_t         m_mode       = M_TURN;
  int            m_left       = T - 1;
  int            m_age        = 0;      // cycles since the in-flight word was accepted
  logic [DW-1:0] m_out        = '0;
  logic [DW-1:0] m_pinq       = '0;
  logic [DW-1:0] exp_rx_data  = '0;
  logic          exp_rx_valid = 1'b0;
  bit            cs_hist[S];            // [0] = newest chip_select sample
  bit            st_hist[S+1];

  always @(posedge clk) begin : model
    bit            cs_seen;
    bit            rise;
    logic [DW-1:0] pin_now;
    pin_now = (m_mode == M_WRITE) ? m_out : tb_pin_val;
    if (rst) begin
      m_mode       = M_TURN;
      m_left       = T - 1;
      m_age        = 0;
      m_out        = '0;
      m_pinq       = '0;
      exp_rx_data  = '0;
      exp_rx_valid = 1'b0;
      for (int i = 0; i < S; i++) cs_hist[i] = 1'b0;
      for (int i = 0; i <= S; i++) st_hist[i] = 1'b0;
    end else begin
      cs_seen      = cs_hist[S-1];
      rise         = st_hist[S-1] && !st_hist[S];
      exp_rx_valid = 1'b0;
      case (m_mode)
        M_TURN: begin
          if (m_left != 0) m_left = m_left - 1;
          else begin
            m_mode = cs_seen ? M_READ : M_WRITE;
            m_age  = 0;
          end
        end
        M_READ: begin
          if (rise) begin
            exp_rx_data  = m_pinq;
            exp_rx_valid = 1'b1;
          end
          if (!cs_seen) begin
            m_mode = M_TURN;
            m_left = T - 1;
          end
        end
        default: begin
          if (cs_seen) begin
            m_mode = M_TURN;
            m_left = T - 1;
            m_age  = 0;
          end else if (m_age == 0) begin
            if (tx_valid) begin
              m_out = tx_data;
              m_age = 1;
            end
          end else if (m_age == 1) begin
            m_age = 2;
          end else begin
            m_age = 0;
          end
        end
      endcase
      for (int i = S; i > 0; i--) st_hist[i] = st_hist[i-1];
      st_hist[0] = pin_strobe;
      for (int i = S - 1; i > 0; i--) cs_hist[i] = cs_hist[i-1];
      cs_hist[0] = chip_select;
      m_pinq = pin_now;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; chip_select = 1'b0; pin_strobe = 1'b0; tx_valid = 1'b0; tb_pin_val = 8'h00;
    tick(3);
    n_checks++;
    if ({drive_en, tx_ready, hsm_strobe, rx_valid, rx_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got de/rdy/stb/rxv/rxd=%b%b%b%b/%h expected 0000/00",
               drive_en, tx_ready, hsm_strobe, rx_valid, rx_data);
    end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick(1);
      n_checks++;
      if (drive_en !== (c == 3)) begin
        n_fail++;
        $display("FAIL release_drive_c%0d: got %b expected %b", c, drive_en, (c == 3));
      end
    end
    n_checks++;
    if ({tx_ready, data_pins} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL release_ready_pins: got %b/%h expected 1/00", tx_ready, data_pins);
    end
  endtask

  task automatic test_write();
    int            first;
    int            second;
    int            sent;
    logic [DW-1:0] p1;
    logic [DW-1:0] p2;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    n_checks++;
    if ({data_pins, tx_ready, hsm_strobe} !== {8'hA5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL write_n1: got pins/rdy/stb=%h/%b/%b expected a5/0/0", data_pins, tx_ready, hsm_strobe);
    end
    tick(1);
    n_checks++;
    if ({tx_ready, hsm_strobe} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_n2: got rdy/stb=%b/%b expected 0/1", tx_ready, hsm_strobe);
    end
    tick(1);
    n_checks++;
    if ({tx_ready, hsm_strobe} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_n3: got rdy/stb=%b/%b expected 1/0", tx_ready, hsm_strobe);
    end
    first = -1; second = -1; sent = 0; p1 = '0; p2 = '0;
    tx_data = 8'h01; tx_valid = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      bit acc;
      acc = tx_valid && tx_ready;
      tick(1);
      if (acc) begin
        sent++;
        if (sent == 1) tx_data = 8'h02;
        else tx_valid = 1'b0;
      end
      if (hsm_strobe) begin
        if (first < 0) begin first = t; p1 = data_pins; end
        else if (second < 0) begin second = t; p2 = data_pins; end
      end
    end
    n_checks++;
    if (first < 0 || second < 0 || second - first != 3 || p1 !== 8'h01 || p2 !== 8'h02) begin
      n_fail++;
      $display("FAIL back_to_back: got strobes at %0d,%0d pins %h,%h expected 3 apart with 01,02",
               first, second, p1, p2);
    end
  endtask

  task automatic test_to_read();
    tb_pin_val  = 8'h3C;
    chip_select = 1'b1;
    for (int k = 1; k <= S + T + 2; k++) begin
      tick(1);
      n_checks++;
      if (drive_en !== (k <= S) || rx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL to_read_k%0d: got de/rxv=%b/%b expected %b/0", k, drive_en, rx_valid, (k <= S));
      end
    end
  endtask

  task automatic test_read_capture();
    int pulses;
    int at;
    pulses = 0; at = -1;
    pin_strobe = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      if (rx_valid) begin
        pulses++;
        at = t;
        n_checks++;
        if (rx_data !== 8'h3C) begin
          n_fail++;
          $display("FAIL capture_data: got %h expected 3c", rx_data);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || at != S + 1) begin
      n_fail++;
      $display("FAIL capture_pulse: got %0d pulses at %0d expected 1 at %0d", pulses, at, S + 1);
    end
    pin_strobe = 1'b0;
    tick(3);
  endtask

  task automatic test_turn_edge();
    int pulses;
    pulses = 0;
    chip_select = 1'b0;
    tick(S + T + 4);
    tb_pin_val  = 8'h77;
    chip_select = 1'b1;
    tick(1);
    pin_strobe = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick(1);
      if (rx_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0 || rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL turn_edge: got %0d pulses rx_data %h expected 0 pulses 3c", pulses, rx_data);
    end
    pin_strobe = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_abort();
    chip_select = 1'b0;
    tick(S + T + 4);
    n_checks++;
    if ({drive_en, tx_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_setup: got de/rdy=%b/%b expected 1/1", drive_en, tx_ready);
    end
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    n_checks++;
    if (data_pins !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_pins: got %h expected 5a", data_pins);
    end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({drive_en, tx_ready, hsm_strobe, rx_valid, rx_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_reset: got de/rdy/stb/rxv/rxd=%b%b%b%b/%h expected 0000/00",
               drive_en, tx_ready, hsm_strobe, rx_valid, rx_data);
    end
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (hsm_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_strobe: got %b expected 0", hsm_strobe);
    end
    tick(S + T + 2);
  endtask

  task automatic test_toggle();
    int   low_run;
    logic prev_de;
    low_run = 0;
    prev_de = drive_en;
    tb_pin_val = 8'h99;
    for (int t = 0; t < 60; t++) begin
      chip_select = ~chip_select;
      pin_strobe  = 1'($urandom_range(0, 1));
      tick(1);
      n_checks++;
      if ((drive_en && rx_valid) || (rx_valid && hsm_strobe) ||
          (drive_en && !prev_de && low_run < T) || drive_en !== (m_mode == M_WRITE)) begin
        n_fail++;
        $display("FAIL toggle_t%0d: got de/rxv/stb=%b/%b/%b low_run %0d expected de=%b no overlap gap>=%0d",
                 t, drive_en, rx_valid, hsm_strobe, low_run, (m_mode == M_WRITE), T);
      end
      low_run = drive_en ? 0 : low_run + 1;
      prev_de = drive_en;
    end
    pin_strobe = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 600; t++) begin
      n_checks++;
      if ({drive_en, tx_ready, hsm_strobe, rx_valid, rx_data} !==
          {(m_mode == M_WRITE), (m_mode == M_WRITE && m_age == 0),
           (m_mode == M_WRITE && m_age == 2), exp_rx_valid, exp_rx_data}) begin
        n_fail++;
        $display("FAIL random_t%0d: got de/rdy/stb/rxv/rxd=%b%b%b%b/%h expected %b%b%b%b/%h", t,
                 drive_en, tx_ready, hsm_strobe, rx_valid, rx_data,
                 (m_mode == M_WRITE), (m_mode == M_WRITE && m_age == 0),
                 (m_mode == M_WRITE && m_age == 2), exp_rx_valid, exp_rx_data);
      end
      if (m_mode == M_WRITE) begin
        n_checks++;
        if (data_pins !== m_out) begin
          n_fail++;
          $display("FAIL random_pins_t%0d: got %h expected %h", t, data_pins, m_out);
        end
      end
      if ($urandom_range(0, 11) == 0) chip_select = ~chip_select;
      if ($urandom_range(0, 3) == 0) pin_strobe = ~pin_strobe;
      tb_pin_val = DW'($urandom);
      tx_data    = DW'($urandom);
      tx_valid   = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_to_read();
    test_read_capture();
    test_turn_edge();
    test_reset_abort();
    test_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hsm_bus_transceiver.md
Name: hsm_bus_transceiver

Overview:
- Registered, parametrised bidirectional transceiver between the HSM shared data bus and FPGA-internal logic.
- Direction is set by the HSM chip_select (high = FPGA reads the pins), which is synchronised internally.
- Both directions are separated by a guaranteed high-Z turnaround window.
- Provides a valid/ready write handshake with an outgoing data strobe, and strobe-qualified capture of incoming data.

Parameters:
DATA_WIDTH, 8, width of data_pins, tx_data and rx_data.
SYNC_STAGES, 2, flops in the chip_select and pin_strobe synchronisers; legal range 2..4.
TURNAROUND, 2, cycles the bus stays high-Z on every direction change; must be >= 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
chip_select  input  1  asynchronous from HSM; 1 = FPGA reads the bus, 0 = FPGA drives the bus.
pin_strobe  input  1  asynchronous from HSM; rising edge marks valid data on data_pins.
data_pins  inout  DATA_WIDTH  shared HSM data bus.
tx_data  input  DATA_WIDTH  word to drive onto the bus.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  block accepts tx_data this cycle.
hsm_strobe  output  1  one-cycle pulse telling the HSM the driven word is stable.
rx_data  output  DATA_WIDTH  last captured bus word.
rx_valid  output  1  one-cycle pulse when rx_data updates.
drive_en  output  1  1 while the FPGA drives data_pins.

Behaviour:
- Synchronisers:
  - cs_s = chip_select after SYNC_STAGES flops.
  - st_s = pin_strobe after SYNC_STAGES flops, plus one extra flop st_d for edge detection.
  - pin_q = data_pins registered once every cycle.
  - All synchroniser flops reset to 0.
- FSM, one-hot, states TURN, READ, WRITE. drive_en is the WRITE state flop itself. data_pins = drive_en ? out_q : high-Z.
- Reset:
  - State = TURN, turnaround counter cnt = TURNAROUND-1.
  - Outputs: drive_en 0, tx_ready 0, hsm_strobe 0, rx_valid 0, rx_data 0.
  - Internal: out_q 0, write-phase counter 0.
  - Reset has priority over every event, including mid-write. The bus goes high-Z on the reset edge; no hsm_strobe is emitted for an aborted word.
- TURN:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: go to READ if cs_s = 1, else WRITE.
  - Each TURN visit therefore lasts exactly TURNAROUND cycles.
  - The direction decision uses cs_s at exit, not at entry.
- READ:
  - If cs_s = 0: go to TURN and load cnt = TURNAROUND-1.
  - On st_s & ~st_d (synchronised rising edge) while in READ: rx_data <= pin_q and rx_valid = 1 for exactly one cycle.
  - A strobe held high produces only one capture.
  - Edges occurring in TURN or WRITE are ignored, with no deferred capture.
- WRITE, three-phase handshake:
  - Phase 0: tx_ready = 1 (Moore, from state/phase only). On tx_valid & tx_ready at edge N, out_q <= tx_data and the phase advances.
  - The new word is on the pins from cycle N+1; tx_ready is 0 in cycles N+1 and N+2.
  - hsm_strobe = 1 during cycle N+2 only.
  - Phase returns to 0 and tx_ready = 1 again from cycle N+3. Peak throughput is 1 word per 3 cycles.
  - tx_valid without tx_ready has no effect; tx_data is only sampled at acceptance.
  - out_q holds its value between words and across direction changes.
- Leaving WRITE:
  - If cs_s = 1 in any phase: go to TURN at that edge, load cnt = TURNAROUND-1, reset the phase to 0.
  - drive_en, tx_ready and hsm_strobe all drop at that same edge.
  - An in-flight word is abandoned; a strobe is never emitted after drive_en falls.
  - cs_s rising in the same cycle as an accepted transfer: the transfer is abandoned.
- Invariants:
  - drive_en = 1 only in WRITE.
  - At least TURNAROUND high-Z cycles separate any READ cycle from any driven cycle.
  - rx_valid and hsm_strobe are never high in the same cycle.

Test Plan:
1. Reset 3 cycles with chip_select=0, then release (TURNAROUND=2) -> data_pins high-Z for 2 cycles after release; drive_en=1 and tx_ready=1 from the 3rd cycle; pins show 8'h00.
2. In WRITE, present tx_data=8'hA5 with tx_valid=1 for one cycle at edge N -> pins = 8'hA5 from N+1; hsm_strobe high only in N+2; tx_ready low N+1..N+2, high at N+3. Back-to-back 8'h01, 8'h02 -> two strobes 3 cycles apart.
3. Raise chip_select while driving -> drive_en falls exactly SYNC_STAGES cycles later; pins high-Z for 2 cycles; state READ after that; rx_valid stays 0.
4. In READ, pins = 8'h3C, pin_strobe 0->1 held high 10 cycles -> one rx_valid pulse SYNC_STAGES+1 cycles after the edge; rx_data = 8'h3C; no further pulses. Strobe edge during TURN -> no capture.
5. Accept 8'h5A, then assert rst in cycle N+1 -> pins high-Z from the reset edge; no hsm_strobe; all outputs at reset values.
6. Toggle chip_select at 1-cycle pulse widths -> drive_en never coincides with a READ capture; every drive_en rise is preceded by >= 2 high-Z cycles.
